// File: rtl/sha256_host_pkg.sv
// Shared constants and types for the sha256 streaming host.
// The core has a fixed 10-bit word interface, so the message, chunk and
// digest geometry are set here and every host file uses them.
package sha256_host_pkg;

   localparam int MESSAGE_LEN            = 640;
   localparam int CHUNK_W                = 10;
   localparam int DIGEST_W               = 256;
   localparam int CHUNKS                 = MESSAGE_LEN / CHUNK_W;
   localparam int OUT_WORDS              = (DIGEST_W + CHUNK_W - 1) / CHUNK_W;
   localparam int COLLECT_W              = OUT_WORDS * CHUNK_W;
   localparam int PAD_BITS               = COLLECT_W - DIGEST_W;
   localparam int DEFAULT_TIMEOUT_CYCLES = 2048;

   // Job sequencing states of the host.
   typedef enum logic [2:0] {
      IDLE,
      CRST,
      START,
      SEND,
      WAIT,
      DONE
   } state_t;

endpackage : sha256_host_pkg

// File: rtl/sha256_word_collector.sv
// Collects the core's hash words into a shift register and watches the
// response deadline. done rises once all OUT_WORDS words are in; timeout
// rises once the deadline counter reaches its last value.
module sha256_word_collector
   import sha256_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                enable,
   input  logic [CHUNK_W-1:0]  hash_word,
   input  logic                hash_valid,
   output logic                done,
   output logic                timeout,
   output logic [DIGEST_W-1:0] digest
);

   localparam int WCNT_W = $clog2(OUT_WORDS + 1);
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WCNT_W-1:0] ALL_WORDS = WCNT_W'(OUT_WORDS);
   localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic [COLLECT_W-1:0] collect;
   logic [WCNT_W-1:0]    word_cnt;
   logic [TCNT_W-1:0]    cycle_cnt;
   logic                 take;

   // A word is taken only while collecting and only until the set is full,
   // so a core holding valid high after its last word changes nothing.
   assign take    = enable && hash_valid && (word_cnt < ALL_WORDS);
   assign done    = (word_cnt == ALL_WORDS);
   assign timeout = (cycle_cnt == TCNT_MAX);

   // The first word received ends up in the top bits; the pad bits that
   // follow the last digest bit are dropped.
   assign digest  = collect[COLLECT_W-1:PAD_BITS];

   // Shift accepted hash words in, most significant word first.
   always_ff @(posedge clk) begin
      if (clear) begin
         collect <= '0;
      end else if (take) begin
         collect <= {collect[COLLECT_W-CHUNK_W-1:0], hash_word};
      end
   end

   // Count received words and cycles spent collecting; the cycle count saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt  <= '0;
         cycle_cnt <= '0;
      end else if (clear) begin
         word_cnt  <= '0;
         cycle_cnt <= '0;
      end else if (enable) begin
         if (take) begin
            word_cnt <= word_cnt + 1'b1;
         end
         if (cycle_cnt != TCNT_MAX) begin
            cycle_cnt <= cycle_cnt + 1'b1;
         end
      end
   end

endmodule : sha256_word_collector

// File: rtl/sha256_stream_host.sv
// Host-side driver and collector for the sha256 streaming core.
// Takes one 640-bit message per job, resets and starts the core, streams
// the message as 64 ten-bit chunks, then reassembles the 26 returned hash
// words into a 256-bit digest offered on a valid/ready handshake.
module sha256_stream_host
   import sha256_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   msg_valid,
   output logic                   msg_ready,
   input  logic [MESSAGE_LEN-1:0] msg_data,
   output logic                   core_rst_n,
   output logic                   core_start,
   output logic                   core_valid_in,
   output logic [CHUNK_W-1:0]     core_message_in,
   input  logic [CHUNK_W-1:0]     core_hash_out,
   input  logic                   core_valid_out,
   output logic                   digest_valid,
   input  logic                   digest_ready,
   output logic [DIGEST_W-1:0]    digest,
   output logic                   err_timeout,
   output logic                   busy
);

   localparam int CCNT_W = $clog2(CHUNKS);
   localparam logic [CCNT_W-1:0] LAST_CHUNK = CCNT_W'(CHUNKS - 1);

   state_t                 state;
   logic [MESSAGE_LEN-1:0] shreg;
   logic [CCNT_W-1:0]      chunk_cnt;
   logic                   accept;
   logic                   col_done;
   logic                   col_timeout;
   logic [DIGEST_W-1:0]    col_digest;

   // msg_ready is only ever high in IDLE, but qualifying with the state keeps
   // the intent explicit.
   assign accept = (state == IDLE) && msg_valid && msg_ready;

   sha256_word_collector #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_collector (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (accept),
      .enable     (state == WAIT),
      .hash_word  (core_hash_out),
      .hash_valid (core_valid_out),
      .done       (col_done),
      .timeout    (col_timeout),
      .digest     (col_digest)
   );

   // Load the message on accept, then shift one chunk out per START/SEND cycle.
   // NOTE: payload registers have no reset: they are always loaded before they
   // are read, so keeping them off the reset net costs nothing functionally.
   always_ff @(posedge clk) begin
      if (accept) begin
         shreg <= msg_data;
      end else if (state == START || state == SEND) begin
         shreg <= {shreg[MESSAGE_LEN-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
      end
   end

   // Job sequencer: every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         msg_ready       <= 1'b0;
         core_rst_n      <= 1'b0;
         core_start      <= 1'b0;
         core_valid_in   <= 1'b0;
         core_message_in <= '0;
         digest_valid    <= 1'b0;
         digest          <= '0;
         err_timeout     <= 1'b0;
         busy            <= 1'b0;
         chunk_cnt       <= '0;
      end else begin
         // NOTE: core_start defaults low every cycle, so the single assignment
         // in CRST yields exactly a one-cycle pulse.
         core_start <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  msg_ready  <= 1'b0;
                  core_rst_n <= 1'b0;
                  busy       <= 1'b1;
                  chunk_cnt  <= '0;
                  state      <= CRST;
               end else begin
                  msg_ready  <= 1'b1;
                  core_rst_n <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            CRST: begin
               // The core clears its load counter only on its own reset,
               // so this one-cycle pulse precedes every job.
               core_rst_n <= 1'b1;
               core_start <= 1'b1;
               state      <= START;
            end
            START: begin
               core_valid_in   <= 1'b1;
               core_message_in <= shreg[MESSAGE_LEN-1 -: CHUNK_W];
               state           <= SEND;
            end
            SEND: begin
               if (chunk_cnt == LAST_CHUNK) begin
                  core_valid_in   <= 1'b0;
                  core_message_in <= '0;
                  state           <= WAIT;
               end else begin
                  chunk_cnt       <= chunk_cnt + 1'b1;
                  core_message_in <= shreg[MESSAGE_LEN-1 -: CHUNK_W];
               end
            end
            WAIT: begin
               // A complete word set wins over a deadline expiring in the same cycle.
               if (col_done) begin
                  digest       <= col_digest;
                  err_timeout  <= 1'b0;
                  digest_valid <= 1'b1;
                  state        <= DONE;
               end else if (col_timeout) begin
                  digest       <= '0;
                  err_timeout  <= 1'b1;
                  digest_valid <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               if (digest_ready) begin
                  digest_valid <= 1'b0;
                  msg_ready    <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The start pulse and the chunk stream never overlap.
   a_start_not_with_chunk : assert property (
      @(posedge clk) disable iff (!rst_n) !(core_start && core_valid_in)
   );

   // A result is only ever offered while the host reports busy.
   a_valid_implies_busy : assert property (
      @(posedge clk) disable iff (!rst_n) digest_valid |-> busy
   );

endmodule : sha256_stream_host
